// File: rtl/serdiv_radix_pkg.sv
// Shared types for the radix serial divider: opcode encoding, FSM states
// and the largest supported quotient-bits-per-cycle setting.
package serdiv_radix_pkg;

    localparam int unsigned DIV_MAX_BPC = 4;

    // Field order gives opcode bit2 = word, bit1 = remainder, bit0 = signed.
    typedef struct packed {
        logic word;
        logic rem;
        logic sgn;
    } div_op_t;

    localparam div_op_t DIV_OP_DIVU  = 3'b000;
    localparam div_op_t DIV_OP_DIV   = 3'b001;
    localparam div_op_t DIV_OP_REMU  = 3'b010;
    localparam div_op_t DIV_OP_REM   = 3'b011;
    localparam div_op_t DIV_OP_DIVUW = 3'b100;
    localparam div_op_t DIV_OP_DIVW  = 3'b101;
    localparam div_op_t DIV_OP_REMUW = 3'b110;
    localparam div_op_t DIV_OP_REMW  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FINISH
    } div_state_e;

endpackage

// File: rtl/serdiv_radix_if.sv
// Operand/result handshake bundle between the issue stage and the divider.
interface serdiv_radix_if
    import serdiv_radix_pkg::*;
#(
    parameter int unsigned WIDTH         = 64,
    parameter int unsigned TRANS_ID_BITS = 3
);
    logic [TRANS_ID_BITS-1:0] id_i;
    logic [WIDTH-1:0]         op_a_i;
    logic [WIDTH-1:0]         op_b_i;
    div_op_t                  opcode_i;
    logic                     in_vld_i;
    logic                     in_rdy_o;
    logic                     flush_i;
    logic                     out_vld_o;
    logic                     out_rdy_i;
    logic [TRANS_ID_BITS-1:0] id_o;
    logic [WIDTH-1:0]         res_o;

    modport slave (
        input  id_i, op_a_i, op_b_i, opcode_i, in_vld_i, flush_i, out_rdy_i,
        output in_rdy_o, out_vld_o, id_o, res_o
    );

    modport master (
        output id_i, op_a_i, op_b_i, opcode_i, in_vld_i, flush_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, id_o, res_o
    );
endinterface

// File: rtl/serdiv_radix_step.sv
// One combinational restoring-division step; a disabled step passes the
// partial remainder through untouched and yields a zero quotient bit.
module serdiv_radix_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);
    logic take;

    assign take  = en_i & (rem_i >= div_i);
    assign rem_o = take ? (rem_i - div_i) : rem_i;
    assign q_o   = take;
endmodule

// File: rtl/serdiv_radix.sv
// Serial restoring divider retiring BITS_PER_CYCLE quotient bits per cycle,
// with early exit for trivial operands and RV64 word variants.
module serdiv_radix
    import serdiv_radix_pkg::*;
#(
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned BITS_PER_CYCLE = 2,
    parameter int unsigned TRANS_ID_BITS  = 3
) (
    input logic           clk_i,
    input logic           rst_ni,
    serdiv_radix_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned K     = (BITS_PER_CYCLE > DIV_MAX_BPC) ? DIV_MAX_BPC : BITS_PER_CYCLE;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [CNT_W-1:0] lzc(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = CNT_W'(WIDTH);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (v[i]) n = CNT_W'(WIDTH - 1 - i);
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] v);
        return {{(WIDTH-32){v[31]}}, v[31:0]};
    endfunction

    div_state_e               state_q, state_d;
    logic [TRANS_ID_BITS-1:0] id_q;
    logic                     rem_op_q, word_op_q, a_neg_q, q_neg_q;
    logic [WIDTH-1:0]         rem_q, div_q, quo_q;
    logic [CNT_W-1:0]         steps_q;

    // Accept-side operand conditioning
    logic signed [WIDTH-1:0] a_ext, b_ext;
    logic [WIDTH-1:0]        abs_a, abs_b;
    logic                    a_neg, b_neg, a_zero, b_zero, min_ovf, special, accept;
    logic [CNT_W-1:0]        lzc_a, lzc_b;
    logic signed [CNT_W:0]   shift;

    always_comb begin
        a_ext = bus.op_a_i;
        b_ext = bus.op_b_i;
        if (bus.opcode_i.word) begin
            a_ext = bus.opcode_i.sgn ? sext_word(bus.op_a_i) : {{(WIDTH-32){1'b0}}, bus.op_a_i[31:0]};
            b_ext = bus.opcode_i.sgn ? sext_word(bus.op_b_i) : {{(WIDTH-32){1'b0}}, bus.op_b_i[31:0]};
        end
    end

    assign a_neg   = bus.opcode_i.sgn & a_ext[WIDTH-1];
    assign b_neg   = bus.opcode_i.sgn & b_ext[WIDTH-1];
    assign abs_a   = cond_neg(a_ext, a_neg);
    assign abs_b   = cond_neg(b_ext, b_neg);
    assign lzc_a   = lzc(abs_a);
    assign lzc_b   = lzc(abs_b);
    assign shift   = $signed({1'b0, lzc_b}) - $signed({1'b0, lzc_a});
    assign a_zero  = (abs_a == '0);
    assign b_zero  = (abs_b == '0);
    assign min_ovf = bus.opcode_i.sgn & ~bus.opcode_i.word & (a_ext == MIN_VAL) & (b_ext == '1);
    assign special = b_zero | a_zero | min_ovf | (shift < 0);
    assign accept  = bus.in_vld_i & bus.in_rdy_o;

    // Iteration datapath: K chained steps, steps beyond the remaining count masked
    logic [WIDTH-1:0] rem_chain [K+1];
    logic [K-1:0]     qbit, step_en;
    logic [WIDTH-1:0] quo_step;
    logic [CNT_W-1:0] steps_next;
    logic             last_iter;

    assign rem_chain[0] = rem_q;

    for (genvar g = 0; g < K; g++) begin : g_step
        assign step_en[g] = (steps_q > CNT_W'(g));
        serdiv_radix_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (rem_chain[g]),
            .div_i (div_q >> g),
            .en_i  (step_en[g]),
            .rem_o (rem_chain[g+1]),
            .q_o   (qbit[g])
        );
    end

    always_comb begin
        quo_step = quo_q;
        for (int unsigned j = 0; j < K; j++) begin
            if (step_en[j]) quo_step = {quo_step[WIDTH-2:0], qbit[j]};
        end
    end

    assign last_iter  = (steps_q <= CNT_W'(K));
    assign steps_next = last_iter ? '0 : (steps_q - CNT_W'(K));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? FINISH : DIVIDE;
            DIVIDE:  if (last_iter) state_d = FINISH;
            FINISH:  if (bus.out_rdy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush_i) state_d = IDLE;
    end

    // Data registers carry no reset; outputs are gated by the FINISH state
    always_ff @(posedge clk_i) begin
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_q      <= bus.id_i;
                    rem_op_q  <= bus.opcode_i.rem;
                    word_op_q <= bus.opcode_i.word;
                    a_neg_q   <= a_neg;
                    q_neg_q   <= bus.opcode_i.sgn & (a_neg ^ b_neg) & ~b_zero;
                    rem_q     <= min_ovf ? '0 : abs_a;
                    div_q     <= abs_b << shift[CNT_W-1:0];
                    quo_q     <= b_zero ? '1 : (min_ovf ? MIN_VAL : '0);
                    steps_q   <= shift[CNT_W-1:0] + CNT_W'(1);
                end
            end
            DIVIDE: begin
                rem_q   <= rem_chain[K];
                div_q   <= div_q >> K;
                quo_q   <= quo_step;
                steps_q <= steps_next;
            end
            default: ;
        endcase
    end

    logic [WIDTH-1:0] res_full, res_fin;

    assign res_full = rem_op_q ? cond_neg(rem_q, a_neg_q) : cond_neg(quo_q, q_neg_q);
    assign res_fin  = word_op_q ? sext_word(res_full) : res_full;

    assign bus.in_rdy_o  = (state_q == IDLE) & ~bus.flush_i;
    assign bus.out_vld_o = (state_q == FINISH) & ~bus.flush_i;
    assign bus.res_o     = (state_q == FINISH) ? res_fin : '0;
    assign bus.id_o      = (state_q == FINISH) ? id_q : '0;
endmodule

// File: tb/tb_serdiv_radix.sv
// Drives three dividers (1, 2 and 4 bits per cycle) in lockstep and checks
// every cycle against an arithmetic reference of RISC-V division semantics.
module tb_serdiv_radix;
    import serdiv_radix_pkg::*;

    localparam int W  = 64;
    localparam int TB = 3;
    localparam int ND = 3;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [TB-1:0] id_drv = '0;
    logic [63:0]   a_drv = '0, b_drv = '0;
    logic [2:0]    op_drv = '0;
    logic          vld_drv = 1'b0, flush_drv = 1'b0, rdy_drv = 1'b1;

    logic [ND-1:0] in_rdy_w, out_vld_w;
    logic [63:0]   res_w [ND];
    logic [TB-1:0] id_w  [ND];

    for (genvar k = 0; k < ND; k++) begin : g_dut
        serdiv_radix_if #(.WIDTH(W), .TRANS_ID_BITS(TB)) bus ();
        assign bus.id_i      = id_drv;
        assign bus.op_a_i    = a_drv;
        assign bus.op_b_i    = b_drv;
        assign bus.opcode_i  = div_op_t'(op_drv);
        assign bus.in_vld_i  = vld_drv;
        assign bus.flush_i   = flush_drv;
        assign bus.out_rdy_i = rdy_drv;
        assign in_rdy_w[k]   = bus.in_rdy_o;
        assign out_vld_w[k]  = bus.out_vld_o;
        assign res_w[k]      = bus.res_o;
        assign id_w[k]       = bus.id_o;
        serdiv_radix #(.WIDTH(W), .BITS_PER_CYCLE(1 << k), .TRANS_ID_BITS(TB)) dut (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .bus    (bus)
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] ext_op(input logic [63:0] x, input logic [2:0] op);
        if (op[2]) return op[0] ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]};
        return x;
    endfunction

    function automatic logic [63:0] mag(input logic [63:0] x, input logic [2:0] op);
        logic [63:0] e;
        e = ext_op(x, op);
        return (op[0] && e[63]) ? -e : e;
    endfunction

    function automatic int msb(input logic [63:0] v);
        int m;
        m = -1;
        for (int i = 0; i < 64; i++) if (v[i]) m = i;
        return m;
    endfunction

    function automatic int model_lat(input logic [63:0] a, b, input logic [2:0] op, input int k);
        logic [63:0] ma, mb;
        int s;
        ma = mag(a, op);
        mb = mag(b, op);
        if (ma == 0 || mb == 0) return 1;
        if (op[0] && !op[2] && ext_op(a, op) == MIN64 && ext_op(b, op) == '1) return 1;
        s = msb(ma) - msb(mb);
        if (s < 0) return 1;
        return (s + k) / k + 1;
    endfunction

    function automatic logic [63:0] model_res(input logic [63:0] a, b, input logic [2:0] op);
        logic [31:0] x, y, r32;
        logic [63:0] r;
        if (op[2]) begin
            x = a[31:0];
            y = b[31:0];
            if (y == 0)                                    r32 = op[1] ? x : 32'hFFFF_FFFF;
            else if (op[0] && x == 32'h8000_0000 && y == '1) r32 = op[1] ? 32'd0 : x;
            else if (op[0])                                r32 = op[1] ? 32'($signed(x) % $signed(y)) : 32'($signed(x) / $signed(y));
            else                                           r32 = op[1] ? x % y : x / y;
            return {{32{r32[31]}}, r32};
        end
        if (b == 0)                             r = op[1] ? a : '1;
        else if (op[0] && a == MIN64 && b == '1) r = op[1] ? 64'd0 : MIN64;
        else if (op[0])                         r = op[1] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
        else                                    r = op[1] ? a % b : a / b;
        return r;
    endfunction

    // ---------------- compare process ----------------
    int errors = 0;
    int checks = 0;
    logic [ND-1:0] pend = '0;
    int cnt [ND], lat [ND], first_vld [ND];
    logic [63:0]   exp_res [ND];
    logic [TB-1:0] exp_id  [ND];

    logic        lit_on = 1'b0;
    logic [63:0] lit_res = '0;
    int          lit_lat [ND] = '{-1, -1, -1};

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            if (!rst_n) begin
                chk("rst_in_rdy", k, 64'(in_rdy_w[k]), 64'd1);
                chk("rst_out_vld", k, 64'(out_vld_w[k]), 64'd0);
                chk("rst_res", k, res_w[k], 64'd0);
                chk("rst_id", k, 64'(id_w[k]), 64'd0);
                pend[k] = 1'b0;
            end else begin
                logic fin;
                fin = pend[k] && (cnt[k] >= lat[k]);
                chk("out_vld", k, 64'(out_vld_w[k]), 64'(fin && !flush_drv));
                chk("in_rdy", k, 64'(in_rdy_w[k]), 64'(!pend[k] && !flush_drv));
                if (fin) begin
                    chk("res", k, res_w[k], exp_res[k]);
                    chk("id", k, 64'(id_w[k]), 64'(exp_id[k]));
                end
                if (pend[k] && out_vld_w[k] && first_vld[k] < 0) first_vld[k] = cnt[k];
                if (flush_drv) begin
                    pend[k] = 1'b0;
                end else if (pend[k]) begin
                    if (fin && rdy_drv) begin
                        pend[k] = 1'b0;
                        if (lit_on) chk("lit_res", k, res_w[k], lit_res);
                        if (lit_lat[k] >= 0) chk("lit_lat", k, 64'(first_vld[k]), 64'(lit_lat[k]));
                    end else begin
                        cnt[k]++;
                    end
                end else if (vld_drv) begin
                    pend[k]      = 1'b1;
                    cnt[k]       = 1;
                    first_vld[k] = -1;
                    lat[k]       = model_lat(a_drv, b_drv, op_drv, 1 << k);
                    exp_res[k]   = model_res(a_drv, b_drv, op_drv);
                    exp_id[k]    = id_drv;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rdy_rand = 1'b0;

    task automatic wait_idle();
        int n;
        n = 0;
        while (pend != '0) begin
            rdy_drv = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk);
            #1;
            n++;
            if (n > 1000) begin
                $display("FAIL timeout waiting for results: pend=%b", pend);
                $fatal(1);
            end
        end
    endtask

    task automatic start(input logic [63:0] a, b, input logic [2:0] op, input logic [TB-1:0] id,
                         input bit lon, input logic [63:0] lres, input int l0, l1, l2);
        wait_idle();
        a_drv = a; b_drv = b; op_drv = op; id_drv = id; vld_drv = 1'b1;
        lit_on = lon; lit_res = lres; lit_lat = '{l0, l1, l2};
        @(posedge clk);
        #1;
        vld_drv = 1'b0;
    endtask

    task automatic do_op(input logic [63:0] a, b, input logic [2:0] op, input logic [TB-1:0] id,
                         input bit lon, input logic [63:0] lres, input int l0, l1, l2);
        start(a, b, op, id, lon, lres, l0, l1, l2);
        wait_idle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_op(64'd100, 64'd7, DIV_OP_DIVU, 3'd1, 1, 64'd14, -1, -1, -1);
        do_op(64'd100, 64'd7, DIV_OP_REMU, 3'd2, 1, 64'd2, -1, -1, -1);
        do_op(-64'sd100, 64'd7, DIV_OP_DIV, 3'd3, 1, -64'sd14, -1, -1, -1);
        do_op(-64'sd100, 64'd7, DIV_OP_REM, 3'd4, 1, -64'sd2, -1, -1, -1);
        do_op(MIN64, '1, DIV_OP_DIV, 3'd5, 1, MIN64, 1, 1, 1);
        do_op(MIN64, '1, DIV_OP_REM, 3'd6, 1, 64'd0, 1, 1, 1);
        do_op(64'd12345, 64'd0, DIV_OP_DIVU, 3'd7, 1, '1, 1, 1, 1);
        do_op(64'd5, 64'd0, DIV_OP_REMU, 3'd0, 1, 64'd5, 1, 1, 1);
        do_op(64'hFFFF_FFFF_8000_0000, 64'd2, DIV_OP_DIVW, 3'd1, 1, 64'hFFFF_FFFF_C000_0000, -1, -1, -1);
        do_op(64'h1_FFFF_FFFE, 64'd1, DIV_OP_DIVUW, 3'd2, 1, 64'hFFFF_FFFF_FFFF_FFFE, -1, -1, -1);
        do_op('1, 64'd1, DIV_OP_DIVU, 3'd3, 1, '1, 65, 33, 17);
        do_op(64'd3, 64'd5, DIV_OP_REMU, 3'd4, 1, 64'd3, 1, 1, 1);
        do_op(64'd0, 64'd7, DIV_OP_DIVU, 3'd5, 1, 64'd0, 1, 1, 1);

        // result held while out_rdy_i is low, then a fresh ID right after release
        start(64'd1000, 64'd3, DIV_OP_DIVU, 3'd6, 1, 64'd333, -1, -1, -1);
        rdy_drv = 1'b0;
        repeat (15) @(posedge clk);
        #1 rdy_drv = 1'b1;
        wait_idle();
        do_op(64'd1000, 64'd3, DIV_OP_REMU, 3'd2, 1, 64'd1, -1, -1, -1);

        // flush mid-divide with a competing 1/1 request in the flush cycle
        start(64'h4000_0000_0000_0000, 64'd1, DIV_OP_DIVU, 3'd7, 0, '0, -1, -1, -1);
        repeat (2) @(posedge clk);
        #1;
        flush_drv = 1'b1; vld_drv = 1'b1; a_drv = 64'd1; b_drv = 64'd1; op_drv = DIV_OP_DIVU; id_drv = 3'd5;
        @(posedge clk);
        #1;
        flush_drv = 1'b0; vld_drv = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // asynchronous reset in the middle of a long divide
        start('1, 64'd3, DIV_OP_DIVU, 3'd4, 0, '0, -1, -1, -1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_op(64'd1, 64'd1, DIV_OP_DIVU, 3'd1, 1, 64'd1, 2, 2, 2);

        // randomized sweep with random result back-pressure
        rdy_rand = 1'b1;
        for (int t = 0; t < 200; t++) begin
            logic [63:0] a, b;
            logic [2:0]  op;
            a  = {$urandom, $urandom} >> $urandom_range(0, 63);
            b  = {$urandom, $urandom} >> $urandom_range(0, 63);
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: b = '0;
                1: b = '1;
                2: a = MIN64;
                3: a = '0;
                default: ;
            endcase
            do_op(a, b, op, 3'($urandom_range(0, 7)), 0, '0, -1, -1, -1);
        end
        rdy_rand = 1'b0;
        rdy_drv = 1'b1;
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
